sync_pulse_gen_mc: RTL

- Multi-channel, parametrised successor of the single-channel toggle sync generator.
- Each channel runs an independent period counter and produces a sync output in one of two modes:
  - toggle: 50 % square wave, compatible with the legacy generator;
  - pulse: programmable high width.
- Each channel also has a programmable start phase, a one-cycle tick strobe and glitch-free period updates at period boundaries.
- Sits between the register/config block and the sensor/ADC sync consumers.

---
 rtl/sync_gen_pkg.sv | 32 +++
 rtl/sync_pulse_ch.sv | 110 +++++++++++
 rtl/sync_pulse_gen_mc.sv | 44 ++++
 3 files changed

// File: rtl/sync_gen_pkg.sv
`default_nettype none
// sync_gen_pkg: shared types and helpers for the multi-channel sync generator.
// Rev 1.0
package sync_gen_pkg;

  typedef enum logic {
    MODE_TOGGLE = 1'b0,
    MODE_PULSE  = 1'b1
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PHASE = 2'd1,
    ST_RUN   = 2'd2
  } ch_state_e;

  // Fields are zero-extended to 64 bits by the caller, so CNT_W up to 64 is supported.
  function automatic logic cfg_valid(input logic [63:0] period,
                                     input logic [63:0] high,
                                     input mode_e       mode);
    return (period >= 64'd2) && !((mode == MODE_PULSE) && (high > period));
  endfunction

  // Output level in the cycle that carries a tick.
  function automatic logic tick_level(input mode_e mode,
                                      input logic  high_nz,
                                      input logic  cur);
    return (mode == MODE_PULSE) ? high_nz : ~cur;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_pulse_ch.sv
`default_nettype none
// sync_pulse_ch: one sync channel -- phase delay, period counter, toggle/pulse output.
// Rev 1.0
module sync_pulse_ch
  import sync_gen_pkg::*;
#(
  parameter int CNT_W      = 32,
  parameter int RST_PERIOD = 500000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             mode,
  input  logic [CNT_W-1:0] period,
  input  logic [CNT_W-1:0] high,
  input  logic [CNT_W-1:0] phase,
  input  logic             resync,
  output logic             sync,
  output logic             tick,
  output logic             cfg_err
);

  localparam logic [CNT_W-1:0] C_ONE        = CNT_W'(1);
  localparam logic [CNT_W-1:0] C_RST_PERIOD = CNT_W'(RST_PERIOD);
  localparam logic [CNT_W-1:0] C_RST_HIGH   = CNT_W'(RST_PERIOD / 2);

  ch_state_e        state;
  mode_e            mode_sh;
  mode_e            mode_in;
  mode_e            nxt_mode;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic [CNT_W-1:0] period_sh;
  logic [CNT_W-1:0] high_sh;
  logic [CNT_W-1:0] phase_sh;
  logic [CNT_W-1:0] nxt_high;
  logic             cfg_ok;
  logic             period_end;
  logic             phase_done;

  assign mode_in    = mode ? MODE_PULSE : MODE_TOGGLE;
  assign cfg_ok     = cfg_valid(64'(period), 64'(high), mode_in);
  assign cnt_inc    = cnt + C_ONE;
  assign period_end = (cnt == period_sh - C_ONE);
  assign phase_done = (cnt == phase_sh);
  // At a period boundary the new tick already uses the freshly accepted config.
  assign nxt_mode   = cfg_ok ? mode_in : mode_sh;
  assign nxt_high   = cfg_ok ? high : high_sh;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      period_sh <= C_RST_PERIOD;
      high_sh   <= C_RST_HIGH;
      phase_sh  <= '0;
      mode_sh   <= MODE_TOGGLE;
      sync      <= 1'b0;
      tick      <= 1'b0;
      cfg_err   <= 1'b0;
    end else begin
      cfg_err <= ~cfg_ok;
      tick    <= 1'b0;
      if (!enable) begin
        state <= ST_IDLE;
        cnt   <= '0;
        sync  <= 1'b0;
      end else if ((state == ST_IDLE) || resync) begin
        // Start and resync share the reload path; a running channel resyncs even on bad config.
        cnt  <= '0;
        sync <= 1'b0;
        if (cfg_ok) begin
          period_sh <= period;
          high_sh   <= high;
          phase_sh  <= phase;
          mode_sh   <= mode_in;
        end
        if (cfg_ok || (state != ST_IDLE)) begin
          state <= ST_PHASE;
        end
      end else if (state == ST_PHASE) begin
        if (phase_done) begin
          state <= ST_RUN;
          cnt   <= '0;
          tick  <= 1'b1;
          sync  <= tick_level(mode_sh, high_sh != '0, sync);
        end else begin
          cnt <= cnt_inc;
        end
      end else if (period_end) begin
        cnt  <= '0;
        tick <= 1'b1;
        sync <= tick_level(nxt_mode, nxt_high != '0, sync);
        if (cfg_ok) begin
          period_sh <= period;
          high_sh   <= high;
          phase_sh  <= phase;
          mode_sh   <= mode_in;
        end
      end else begin
        cnt <= cnt_inc;
        if (mode_sh == MODE_PULSE) begin
          sync <= (cnt_inc < high_sh);
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/sync_pulse_gen_mc.sv
`default_nettype none
// sync_pulse_gen_mc: N_CH independent sync generators sharing one resync strobe.
// Rev 1.0
module sync_pulse_gen_mc #(
  parameter int N_CH       = 2,
  parameter int CNT_W      = 32,
  parameter int RST_PERIOD = 500000
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [N_CH-1:0]       i_enable,
  input  logic [N_CH-1:0]       i_mode,
  input  logic [N_CH*CNT_W-1:0] i_period,
  input  logic [N_CH*CNT_W-1:0] i_high,
  input  logic [N_CH*CNT_W-1:0] i_phase,
  input  logic                  i_resync,
  output logic [N_CH-1:0]       o_sync,
  output logic [N_CH-1:0]       o_tick,
  output logic [N_CH-1:0]       o_cfg_err
);

  generate
    for (genvar c = 0; c < N_CH; c++) begin : g_ch
      sync_pulse_ch #(
        .CNT_W      (CNT_W),
        .RST_PERIOD (RST_PERIOD)
      ) u_ch (
        .clk     (i_clk),
        .rst_n   (i_rst_n),
        .enable  (i_enable[c]),
        .mode    (i_mode[c]),
        .period  (i_period[c*CNT_W +: CNT_W]),
        .high    (i_high[c*CNT_W +: CNT_W]),
        .phase   (i_phase[c*CNT_W +: CNT_W]),
        .resync  (i_resync),
        .sync    (o_sync[c]),
        .tick    (o_tick[c]),
        .cfg_err (o_cfg_err[c])
      );
    end
  endgenerate

endmodule
`default_nettype wire
